// File: rtl/mem_access_unit.sv
// Load/store bus initiator for the single-cycle RAM controller.
// Accepts one RV32 load/store at a time, checks it, runs the addr/data/rw/size
// bus handshake and returns a one-cycle response with extended read data.
module mem_access_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] bus_addr,
  inout  logic [31:0] bus_data,
  output logic        bus_rw,
  output logic [1:0]  bus_size
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR_ISSUE,
    RESP
  } state_t;

  state_t state, state_nx;

  logic        accept;
  logic [1:0]  dec_size;
  logic        dec_illegal;
  logic        dec_misal;
  logic        dec_oor;
  logic        dec_fault;
  logic [31:0] dec_wdata;

  // Latched request fields used after acceptance
  logic [31:0] wdata_q;
  logic        zext_q;

  // Next values of every registered output
  logic        req_ready_nx;
  logic        resp_valid_nx;
  logic        resp_fault_nx;
  logic [31:0] resp_rdata_nx;
  logic [31:0] bus_addr_nx;
  logic        bus_rw_nx;
  logic [1:0]  bus_size_nx;
  logic [31:0] wdata_nx;
  logic        zext_nx;

  assign accept = req_valid && req_ready;

  // Write data is released whenever no write beat is on the bus, including
  // the instant reset clears bus_size.
  assign bus_data = (bus_rw && (bus_size != 2'b00)) ? wdata_q : 'z;

  // Decode width, legality, alignment and range of the presented request
  always_comb begin
    dec_size = 2'b00;
    case (req_funct3[1:0])
      2'b00:   dec_size = 2'b01;
      2'b01:   dec_size = 2'b10;
      2'b10:   dec_size = 2'b11;
      default: dec_size = 2'b00;
    endcase

    if (req_we) begin
      dec_illegal = req_funct3[2] || (req_funct3 == 3'b011);
    end else begin
      dec_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                    (req_funct3 == 3'b111);
    end

    dec_misal = ((dec_size == 2'b10) && req_addr[0]) ||
                ((dec_size == 2'b11) && (req_addr[1:0] != 2'b00));
    dec_oor   = (req_addr >= ADDR_LIMIT);
    dec_fault = dec_illegal || dec_misal || dec_oor;

    case (dec_size)
      2'b01:   dec_wdata = {24'h000000, req_wdata[7:0]};
      2'b10:   dec_wdata = {16'h0000, req_wdata[15:0]};
      default: dec_wdata = req_wdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (dec_fault)   state_nx = RESP;
          else if (req_we) state_nx = WR_ISSUE;
          else             state_nx = RD_ISSUE;
        end
      end
      RD_ISSUE:   state_nx = RD_CAPTURE;
      RD_CAPTURE: state_nx = RESP;
      WR_ISSUE:   state_nx = RESP;
      RESP:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // Output values for the coming cycle; they are registered below so every
  // port changes only on a clock edge (or reset).
  always_comb begin
    req_ready_nx  = (state_nx == IDLE);
    resp_valid_nx = (state_nx == RESP);
    resp_fault_nx = 1'b0;
    resp_rdata_nx = '0;
    bus_addr_nx   = bus_addr;
    bus_rw_nx     = bus_rw;
    bus_size_nx   = bus_size;
    wdata_nx      = wdata_q;
    zext_nx       = zext_q;

    case (state)
      IDLE: begin
        if (accept) begin
          if (dec_fault) begin
            resp_fault_nx = 1'b1;
          end else begin
            bus_addr_nx = req_addr;
            bus_rw_nx   = req_we;
            bus_size_nx = dec_size;
            wdata_nx    = req_we ? dec_wdata : '0;
            zext_nx     = req_funct3[2];
          end
        end
      end
      RD_CAPTURE: begin
        case (bus_size)
          2'b01:   resp_rdata_nx = {{24{~zext_q & bus_data[7]}}, bus_data[7:0]};
          2'b10:   resp_rdata_nx = {{16{~zext_q & bus_data[15]}}, bus_data[15:0]};
          default: resp_rdata_nx = bus_data;
        endcase
        bus_rw_nx   = 1'b0;
        bus_size_nx = 2'b00;
      end
      WR_ISSUE: begin
        bus_rw_nx   = 1'b0;
        bus_size_nx = 2'b00;
      end
      default: ;
    endcase
  end

  // Output and request-latch registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      bus_addr   <= '0;
      bus_rw     <= 1'b0;
      bus_size   <= 2'b00;
      wdata_q    <= '0;
      zext_q     <= 1'b0;
    end else begin
      req_ready  <= req_ready_nx;
      resp_valid <= resp_valid_nx;
      resp_fault <= resp_fault_nx;
      resp_rdata <= resp_rdata_nx;
      bus_addr   <= bus_addr_nx;
      bus_rw     <= bus_rw_nx;
      bus_size   <= bus_size_nx;
      wdata_q    <= wdata_nx;
      zext_q     <= zext_nx;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, hand-written
// multi-cycle sequences and randomized traffic against a byte-array model.
module tb_mem_access_unit;

  localparam int unsigned LIMIT = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] bus_addr;
  wire  [31:0] bus_data;
  logic        bus_rw;
  logic [1:0]  bus_size;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.ADDR_LIMIT(32'd1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_rw(bus_rw), .bus_size(bus_size)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // An undriven bus reads as Z on 4-state simulators and 0 on 2-state ones.
  function automatic logic released(input logic [31:0] v);
    return (v === 32'hzzzzzzzz) || (v === 32'h00000000);
  endfunction

  // ---------------- RAM controller on the far side of the bus ----------------
  logic [7:0]  ram [0:LIMIT-1];
  logic [31:0] rdbuf = '0;
  logic        tb_drive = 1'b0;
  logic        rd_phase = 1'b0;
  logic        ram_clear = 1'b1;

  assign bus_data = tb_drive ? rdbuf : 'z;

  // Read buffer is latched at the end of the first read cycle and driven in
  // the second; upper bytes beyond the access width are deliberately live.
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < LIMIT; i++) ram[i] <= 8'h00;
      tb_drive <= 1'b0;
      rd_phase <= 1'b0;
    end else if (bus_size != 2'b00 && bus_rw) begin
      for (int i = 0; i < 4; i++)
        if (i < (1 << (bus_size - 1)))
          ram[(int'(bus_addr) + i) % LIMIT] <= bus_data[8*i +: 8];
      tb_drive <= 1'b0;
      rd_phase <= 1'b0;
    end else if (bus_size != 2'b00) begin
      if (!rd_phase) begin
        for (int i = 0; i < 4; i++)
          rdbuf[8*i +: 8] <= ram[(int'(bus_addr) + i) % LIMIT];
        rd_phase <= 1'b1;
        tb_drive <= 1'b1;
      end else begin
        rd_phase <= 1'b0;
        tb_drive <= 1'b0;
      end
    end else begin
      tb_drive <= 1'b0;
      rd_phase <= 1'b0;
    end
  end

  // ---------------- continuous bus / response invariants ----------------
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid && prev_rv) check("resp_valid_width", 32'd2, 32'd1);
      if (tb_drive) begin
        check("bus_contention_rw", {31'd0, bus_rw}, 32'd0);
      end else if (!(bus_rw && bus_size != 2'b00)) begin
        check("bus_released", {31'd0, released(bus_data)}, 32'd1);
      end
      if (bus_rw && bus_size == 2'b01) check("wr_upper_b", {8'd0, bus_data[31:8]}, 32'd0);
      if (bus_rw && bus_size == 2'b10) check("wr_upper_h", {16'd0, bus_data[31:16]}, 32'd0);
      prev_rv <= resp_valid;
    end else begin
      prev_rv <= 1'b0;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [0:LIMIT-1];

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic exp_fault,
                       output logic [31:0] exp_rdata, output int exp_lat,
                       output logic [1:0] exp_size);
    int nbytes;
    logic legal;
    logic [31:0] v;
    nbytes = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    exp_fault = !legal || (addr % nbytes != 0) || (addr >= LIMIT);
    exp_size = 2'(f3[1:0] + 2'd1);
    exp_rdata = '0;
    if (exp_fault) begin
      exp_lat = 0;
    end else if (we) begin
      for (int i = 0; i < nbytes; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      exp_lat = 1;
    end else begin
      v = '0;
      for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8*i));
      if (nbytes < 4 && !f3[2] && v[8*nbytes-1]) v = v | ~((32'd1 << (8*nbytes)) - 32'd1);
      exp_rdata = v;
      exp_lat = 2;
    end
  endtask

  // ---------------- one transaction through the DUT ----------------
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic fault, output int lat, output int buscyc,
                         output logic [1:0] seen_size, output logic seen_rw,
                         output logic timeout);
    int n;
    timeout = 1'b0; rdata = '0; fault = 1'b0; lat = 0; buscyc = 0;
    seen_size = 2'b00; seen_rw = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin timeout = 1'b1; return; end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    // Scramble request inputs while busy; they must have been latched.
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    while (!resp_valid && lat < 10) begin
      if (bus_size != 2'b00) begin buscyc++; seen_size = bus_size; seen_rw = bus_rw; end
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) begin timeout = 1'b1; return; end
    rdata = resp_rdata;
    fault = resp_fault;
  endtask

  task automatic exercise(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic use_tbl, input logic tf, input logic [31:0] trd,
                          input int tlat);
    logic ef; logic [31:0] erd; int elat; logic [1:0] esz;
    logic [31:0] rd; logic f; int lat, bc; logic [1:0] sz; logic rw; logic to;
    model(we, f3, addr, wdata, ef, erd, elat, esz);
    if (use_tbl) begin ef = tf; erd = trd; elat = tlat; end
    run_txn(we, f3, addr, wdata, rd, f, lat, bc, sz, rw, to);
    check({tag, "_timeout"}, {31'd0, to}, 32'd0);
    if (!to) begin
      check({tag, "_fault"}, {31'd0, f}, {31'd0, ef});
      check({tag, "_rdata"}, rd, erd);
      check({tag, "_latency"}, lat, elat);
      check({tag, "_buscycles"}, bc, elat);
      if (!ef) begin
        check({tag, "_bus_size"}, {30'd0, sz}, {30'd0, esz});
        check({tag, "_bus_rw"}, {31'd0, rw}, {31'd0, we});
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        fault;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int acc[$];
    int nresp;
    int n;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr;

    tbl[0]  = '{1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,        1};
    tbl[1]  = '{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 2};
    tbl[2]  = '{1'b1, 3'd0, 32'h21,  32'h000000F0, 1'b0, 32'h0,        1};
    tbl[3]  = '{1'b0, 3'd0, 32'h21,  32'h0,        1'b0, 32'hFFFFFFF0, 2};
    tbl[4]  = '{1'b0, 3'd4, 32'h21,  32'h0,        1'b0, 32'h000000F0, 2};
    tbl[5]  = '{1'b1, 3'd1, 32'h22,  32'h00008001, 1'b0, 32'h0,        1};
    tbl[6]  = '{1'b0, 3'd1, 32'h22,  32'h0,        1'b0, 32'hFFFF8001, 2};
    tbl[7]  = '{1'b0, 3'd5, 32'h22,  32'h0,        1'b0, 32'h00008001, 2};
    tbl[8]  = '{1'b0, 3'd2, 32'h13,  32'h0,        1'b1, 32'h0,        0};
    tbl[9]  = '{1'b0, 3'd1, 32'h25,  32'h0,        1'b1, 32'h0,        0};
    tbl[10] = '{1'b1, 3'd2, 32'h400, 32'h11111111, 1'b1, 32'h0,        0};
    tbl[11] = '{1'b0, 3'd2, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF, 2};
    tbl[12] = '{1'b0, 3'd3, 32'h10,  32'h0,        1'b1, 32'h0,        0};
    tbl[13] = '{1'b1, 3'd4, 32'h10,  32'h55555555, 1'b1, 32'h0,        0};
    tbl[14] = '{1'b0, 3'd2, 32'h20,  32'h0,        1'b0, 32'h8001F000, 2};
    tbl[15] = '{1'b1, 3'd0, 32'h30,  32'hAAAAAA5A, 1'b0, 32'h0,        1};
    tbl[16] = '{1'b0, 3'd2, 32'h30,  32'h0,        1'b0, 32'h0000005A, 2};
    tbl[17] = '{1'b0, 3'd2, 32'h3FC, 32'h0,        1'b0, 32'h0,        2};

    for (int i = 0; i < LIMIT; i++) ref_mem[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_rw", {31'd0, bus_rw}, 32'd0);
    check("rst_bus_size", {30'd0, bus_size}, 32'd0);
    check("rst_bus_data", {31'd0, released(bus_data)}, 32'd1);
    ram_clear = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 18; i++)
      exercise($sformatf("tbl%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
               1'b1, tbl[i].fault, tbl[i].rdata, tbl[i].lat);

    // Back-to-back loads with req_valid held high
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = '0;
    nresp = 0;
    for (int c = 0; c < 16; c++) begin
      if (req_ready) acc.push_back(c);
      if (resp_valid) begin
        nresp++;
        check("b2b_rdata", resp_rdata, 32'hDEADBEEF);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_accepts", acc.size(), 32'd4);
    check("b2b_responses", nresp, 32'd4);
    for (int i = 1; i < acc.size(); i++) check("b2b_spacing", acc[i] - acc[i-1], 32'd4);

    // Reset hitting a store in WR_ISSUE
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h12345678;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    check("wrrst_pre_size", {30'd0, bus_size}, 32'd3);
    check("wrrst_pre_rw", {31'd0, bus_rw}, 32'd1);
    rst = 1'b1;
    #1;
    check("wrrst_size", {30'd0, bus_size}, 32'd0);
    check("wrrst_data", {31'd0, released(bus_data)}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("wrrst_ready", {31'd0, req_ready}, 32'd1);
    check("wrrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    exercise("wrrst_readback", 1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 2);

    // Randomized traffic against the model
    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 5) == 0) f3 = 3'($urandom);
      else f3 = 3'($urandom_range(0, 2)) | (we ? 3'd0 : 3'($urandom_range(0, 1) << 2));
      case ($urandom_range(0, 9))
        0: addr = $urandom_range(32'hFFFFFFFF, LIMIT);
        1: addr = LIMIT - $urandom_range(1, 4);
        default: begin
          addr = $urandom_range(0, LIMIT - 1);
          if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
        end
      endcase
      exercise("rand", we, f3, addr, $urandom, 1'b0, 1'b0, 32'h0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
